// File: rtl/mips_boot_pkg.sv
// mips_boot_pkg: shared state encoding, default frame start byte and frame-field widths for the boot loader.
package mips_boot_pkg;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, RUN, ERROR} state_t;
  localparam logic [7:0] MAGIC_DEF = 8'hA5;
  localparam int BYTE_W = 8;
  localparam int LEN_W = 16;
  localparam int WORD_W = 32;
endpackage

// File: rtl/boot_word_packer.sv
// boot_word_packer: assembles little-endian 32-bit words from a byte stream and pulses we one cycle after the fourth byte.
module boot_word_packer
  import mips_boot_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic              last_o,
  output logic              we_o,
  output logic [WORD_W-1:0] word_o
);
  logic [1:0]  pos_q;
  logic [23:0] buf_q;
  assign last_o = en_i & (pos_q == 2'd3);
  // Bytes shift in from the top so the first byte ends up in the LSB lane.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pos_q  <= '0;
      buf_q  <= '0;
      we_o   <= 1'b0;
      word_o <= '0;
    end else begin
      we_o <= last_o;
      if (en_i) begin
        pos_q <= pos_q + 2'd1;
        buf_q <= {data_i, buf_q[23:8]};
      end
      if (last_o) word_o <= {data_i, buf_q};
    end
  end
endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a framed program image over a byte stream, writes it to instruction memory,
// verifies its XOR checksum and releases the core from reset on success.
module boot_loader
  import mips_boot_pkg::*;
#(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] MAGIC  = MAGIC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              err
);
  localparam logic [LEN_W:0] CAP = (LEN_W+1)'(1) << ADDR_W;
  state_t             state_q, state_d;
  logic [BYTE_W-1:0]  len_lo_q, csum_q;
  logic [LEN_W-1:0]   count_q, n_len;
  logic [ADDR_W-1:0]  widx_q, imem_addr_q;
  logic               in_ready_q, core_reset_q, done_q, err_q;
  logic               acc, last, last_word;
  assign acc       = in_valid & in_ready_q;
  assign n_len     = {in_data, len_lo_q};
  assign last_word = LEN_W'(widx_q) == count_q - LEN_W'(1);
  assign in_ready   = in_ready_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign err        = err_q;
  assign imem_addr  = imem_addr_q;
  boot_word_packer u_packer (
    .clk   (clk),
    .reset (reset),
    .en_i  (acc && state_q == DATA),
    .data_i(in_data),
    .last_o(last),
    .we_o  (imem_we),
    .word_o(imem_wdata)
  );
  always_comb begin
    state_d = state_q;
    if (acc)
      case (state_q)
        IDLE:    state_d = in_data == MAGIC ? LEN0 : IDLE;
        LEN0:    state_d = LEN1;
        LEN1:    state_d = n_len == '0 ? CSUM : {1'b0, n_len} > CAP ? ERROR : DATA;
        DATA:    state_d = last && last_word ? CSUM : DATA;
        CSUM:    state_d = in_data == csum_q ? RUN : ERROR;
        default: state_d = state_q;
      endcase
  end
  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_lo_q     <= '0;
      count_q      <= '0;
      csum_q       <= '0;
      widx_q       <= '0;
      imem_addr_q  <= '0;
      in_ready_q   <= 1'b1;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= !(state_d inside {RUN, ERROR});
      core_reset_q <= state_d != RUN;
      done_q       <= state_d == RUN;
      err_q        <= state_d == ERROR;
      if (acc && state_q == LEN0) len_lo_q <= in_data;
      if (acc && state_q == LEN1) count_q <= n_len;
      if (acc && state_q == DATA) csum_q <= csum_q ^ in_data;
      if (last) begin
        imem_addr_q <= widx_q;
        widx_q      <= widx_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed frame streams against hand-computed write logs and status flags.
module tb_boot_loader;
  typedef logic [7:0] bq_t[$];
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, imem_we, core_reset, done, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  int          checks = 0;
  int          failures = 0;
  boot_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (imem_we) begin
    wa.push_back(imem_addr);
    wd.push_back(imem_wdata);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wa.delete();
    wd.delete();
  endtask
  task automatic send(input bq_t s, input int maxgap);
    foreach (s[i]) begin
      if (maxgap > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(maxgap)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data = s[i];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask
  task automatic check_good(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_wcnt"}, wa.size(), 2);
    if (wa.size() == 2) begin
      chk({tag, "_a0"}, wa[0], 0);
      chk({tag, "_d0"}, wd[0], 32'h20080005);
      chk({tag, "_a1"}, wa[1], 1);
      chk({tag, "_d1"}, wd[1], 32'h2009000A);
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_corerst"}, core_reset, 0);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_err"}, err, 0);
  endtask
  bq_t s030 = '{8'hA5, 8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h0A, 8'h00, 8'h09, 8'h20, 8'h0E};
  bq_t s031, big;
  initial begin
    do_reset();
    chk("rst_rdy", in_ready, 1);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_corerst", core_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    send(s030, 0);
    chk("good_done_now", done, 1);
    check_good("good");
    chk("good_hold_addr", imem_addr, 1);
    chk("good_hold_wdata", imem_wdata, 32'h2009000A);
    chk("good_we_idle", imem_we, 0);
    do_reset();
    s031 = s030;
    s031[11] = 8'h0F;
    send(s031, 0);
    chk("bad_err_now", err, 1);
    send('{8'hA5, 8'h00}, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("bad_err", err, 1);
    chk("bad_done", done, 0);
    chk("bad_corerst", core_reset, 1);
    chk("bad_rdy", in_ready, 0);
    chk("bad_wcnt", wa.size(), 2);
    do_reset();
    send('{8'h00, 8'hFF, 8'h5A}, 0);
    chk("lead_idle_done", done, 0);
    send(s030, 0);
    check_good("lead");
    do_reset();
    send('{8'hA5, 8'h00, 8'h00}, 0);
    chk("n0_not_yet", done, 0);
    send('{8'h00}, 0);
    chk("n0_done", done, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("n0_wcnt", wa.size(), 0);
    do_reset();
    send('{8'hA5, 8'h01, 8'h01}, 0);
    chk("n257_err", err, 1);
    chk("n257_rdy", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("n257_wcnt", wa.size(), 0);
    do_reset();
    send(s030[0:5], 0);
    do_reset();
    chk("abort_rdy", in_ready, 1);
    chk("abort_done", done, 0);
    send(s030, 3);
    check_good("abort");
    do_reset();
    big = '{8'hA5, 8'h00, 8'h01};
    for (int i = 0; i < 256; i++) big = {big, 8'(i), 8'h00, 8'h00, 8'h00};
    big.push_back(8'h00);
    send(big, 0);
    chk("n256_done", done, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("n256_wcnt", wa.size(), 256);
    if (wa.size() == 256) begin
      chk("n256_last_a", wa[255], 255);
      chk("n256_last_d", wd[255], 32'h000000FF);
      chk("n256_mid_d", wd[100], 32'h00000064);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width (capacity 2^ADDR_W words).
REQ-002 Parameter MAGIC, default 8'hA5, frame start byte.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  byte-stream valid.
REQ-006 in_data  input  8  byte-stream data.
REQ-007 in_ready  output  1  byte accepted on any edge where in_valid & in_ready.
REQ-008 imem_we  output  1  instruction-memory write strobe, one-cycle pulse per word.
REQ-009 imem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 imem_wdata  output  32  instruction word.
REQ-011 core_reset  output  1  active-high reset driven to the processor core.
REQ-012 done  output  1  image loaded and verified; core running.
REQ-013 err  output  1  load failed; sticky until reset.

Function
REQ-014 Frame format: MAGIC, count N as 16-bit little-endian (2 bytes), 4N payload bytes forming little-endian words, then 1 checksum byte equal to the XOR of all payload bytes.
REQ-015 States: IDLE, LEN0, LEN1, DATA, CSUM, RUN, ERROR.
REQ-016 IDLE: accepted byte equal to MAGIC -> LEN0; any other byte is discarded and the block stays in IDLE.
REQ-017 LEN0 -> LEN1 on one accepted byte; LEN1 -> DATA if N in 1..2^ADDR_W, -> CSUM if N=0, -> ERROR if N > 2^ADDR_W.
REQ-018 DATA: bytes fill positions 0..3 of the word (LSB first); accepting byte 3 registers the word, and imem_we=1 for exactly the following cycle with imem_addr = word index (0-based) and imem_wdata = assembled word.
REQ-019 DATA -> CSUM when byte 3 of word N-1 is accepted; word index never wraps.
REQ-020 CSUM: accepted byte equal to running XOR -> RUN; otherwise -> ERROR.
REQ-021 in_ready=1 in IDLE, LEN0, LEN1, DATA, CSUM; in_ready=0 in RUN and ERROR.
REQ-022 Throughput: one byte per cycle when in_valid is held high; in_valid gaps stall without losing state.
REQ-023 core_reset=1 in every state except RUN; falls on the first cycle in RUN.
REQ-024 done=1 only in RUN; err=1 only in ERROR; RUN and ERROR are left only by reset.
REQ-025 imem_we=0 whenever no word write is in progress; imem_addr and imem_wdata hold their last values.

Reset
REQ-026 reset low at a clock edge -> state IDLE, byte and word counters 0, checksum 0, in_ready=1 after release, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, done=0, err=0.
REQ-027 Reset during any state, including mid-word, aborts the frame and discards any partial word. Already-written memory is not erased.

Structure
REQ-028 Package mips_boot_pkg holds the state enum, MAGIC default, and the frame-field widths.
REQ-029 One sub-module, boot_word_packer: byte position counter and 32-bit LE assembler with word-complete pulse; the FSM, counters and checksum stay in boot_loader.

Verification
REQ-030 Stream A5 02 00 05 00 08 20 0A 00 09 20 0E -> writes addr0=20080005, addr1=2009000A; core_reset falls; done=1; in_ready=0.
REQ-031 Same stream with checksum 0F -> no further state change after the checksum byte; err=1; core_reset stays 1; done=0.
REQ-032 Leading bytes 00 FF 5A, then the REQ-030 stream -> identical result; the leading bytes are ignored.
REQ-033 Stream A5 00 00 00 (N=0) -> zero imem_we pulses; done=1 after the fourth byte.
REQ-034 ADDR_W=8, stream A5 01 01 (N=257) -> err=1 after the third byte; no writes.
REQ-035 Reset asserted after the 6th byte of REQ-030, then the full REQ-030 stream with random in_valid gaps -> correct writes and done=1.
